// File: rtl/vliw_pkg.sv
// ---------------------------------------------------------------------------
// vliw_pkg
// Shared types for the VLIW decode-to-execute stage.
//   lane_t        one issue slot: op, is_nop, is_imm_type, rs1, rs2, rd, imm
//   LANE_NOP      canonical empty slot (is_nop=1, everything else zero)
//   idex_state_e  occupancy states of the stage when the skid entry is built
//   force_nop()   returns a slot with is_nop set and all other fields kept
// ---------------------------------------------------------------------------
package vliw_pkg;

    localparam int LANE_OP_W  = 4;
    localparam int LANE_REG_W = 5;
    localparam int LANE_IMM_W = 20;

    typedef struct packed {
        logic [LANE_OP_W-1:0]  op;
        logic                  is_nop;
        logic                  is_imm_type;
        logic [LANE_REG_W-1:0] rs1;
        logic [LANE_REG_W-1:0] rs2;
        logic [LANE_REG_W-1:0] rd;
        logic [LANE_IMM_W-1:0] imm;
    } lane_t;

    localparam lane_t LANE_NOP = '{
        op:          '0,
        is_nop:      1'b1,
        is_imm_type: 1'b0,
        rs1:         '0,
        rs2:         '0,
        rd:          '0,
        imm:         '0
    };

    typedef enum logic [1:0] {
        IDEX_EMPTY = 2'd0,
        IDEX_FULL  = 2'd1,
        IDEX_SKID  = 2'd2
    } idex_state_e;

    function automatic lane_t force_nop(input lane_t l);
        lane_t r;
        r        = l;
        r.is_nop = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/vliw_lane_reg.sv
// ---------------------------------------------------------------------------
// vliw_lane_reg
// Register for a single issue slot.
//   clk   in   rising-edge clock
//   rst   in   synchronous active-low reset, loads LANE_NOP
//   load  in   capture d on this edge
//   kill  in   when loading, mark the captured slot as a NOP
//   d     in   incoming slot payload
//   q     out  registered slot payload
// A killed slot keeps its op/register/immediate fields; only is_nop is forced.
// ---------------------------------------------------------------------------
module vliw_lane_reg
    import vliw_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  kill,
    input  lane_t d,
    output lane_t q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= LANE_NOP;
        end else if (load) begin
            q <= kill ? force_nop(d) : d;
        end
    end

endmodule

// File: rtl/vliw_id_ex_stage.sv
// ---------------------------------------------------------------------------
// vliw_id_ex_stage
// Decode-to-execute pipeline stage carrying one LANES-wide bundle with a
// valid/ready handshake, whole-stage flush and per-lane kill.
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset
//   in_valid   in   decode offers a bundle
//   in_ready   out  stage accepts a bundle this cycle (0 whenever rst is low)
//   in_lane    in   LANES x lane_t payload
//   lane_kill  in   per-lane squash applied at capture
//   flush      in   drop everything held and anything offered this cycle
//   out_valid  out  bundle available to execute (registered)
//   out_ready  in   execute consumes the bundle this cycle
//   out_lane   out  registered payload; is_nop forced to 1 while !out_valid
// Optional feature: define VLIW_ID_EX_SKID_EN to add a second (skid) entry,
// which makes in_ready a registered signal independent of out_ready.
// ---------------------------------------------------------------------------
module vliw_id_ex_stage
    import vliw_pkg::*;
#(
    parameter int LANES = 4,
    parameter int OP_W  = 4,
    parameter int REG_W = 5,
    parameter int IMM_W = 20
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  lane_t [LANES-1:0]      in_lane,
    input  logic  [LANES-1:0]      lane_kill,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output lane_t [LANES-1:0]      out_lane
);

    // The slot layout is fixed by the package; reject mismatched overrides.
    if (OP_W != LANE_OP_W || REG_W != LANE_REG_W || IMM_W != LANE_IMM_W) begin : g_width_check
        $error("vliw_id_ex_stage: lane widths must match vliw_pkg");
    end
    if (LANES < 1 || LANES > 8) begin : g_lanes_check
        $error("vliw_id_ex_stage: LANES must be 1..8");
    end

    lane_t [LANES-1:0] main_d;
    lane_t [LANES-1:0] main_q;
    logic  [LANES-1:0] main_kill;
    logic              main_load;
    logic              in_xfer;

`ifdef VLIW_ID_EX_SKID_EN

    idex_state_e       state;
    logic              valid_q;
    logic              ready_q;
    logic              skid_load;
    logic              main_from_skid;
    lane_t [LANES-1:0] skid_q;

    assign in_ready  = rst & ready_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = valid_q;

    // Decide which entry loads this edge. A bundle arriving while execute
    // stalls lands in the skid entry; when execute drains SKID, the skid
    // entry moves forward into main. Flush suppresses every load.
    always_comb begin
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (!flush) begin
            case (state)
                IDEX_EMPTY: main_load = in_xfer;
                IDEX_FULL: begin
                    if (in_xfer) begin
                        main_load = out_ready;
                        skid_load = !out_ready;
                    end
                end
                IDEX_SKID: begin
                    main_load      = out_ready;
                    main_from_skid = out_ready;
                end
                default: ;
            endcase
        end
    end

    // Skid data already had its kill applied when it was captured.
    assign main_d    = main_from_skid ? skid_q : in_lane;
    assign main_kill = main_from_skid ? '0 : lane_kill;

    // Occupancy FSM with registered valid and ready flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDEX_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else if (flush) begin
            state   <= IDEX_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                IDEX_EMPTY: begin
                    if (in_xfer) begin
                        state   <= IDEX_FULL;
                        valid_q <= 1'b1;
                    end
                end
                IDEX_FULL: begin
                    if (in_xfer && !out_ready) begin
                        state   <= IDEX_SKID;
                        ready_q <= 1'b0;
                    end else if (!in_xfer && out_ready) begin
                        state   <= IDEX_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                IDEX_SKID: begin
                    if (out_ready) begin
                        state   <= IDEX_FULL;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDEX_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_skid
        vliw_lane_reg u_skid (
            .clk  (clk),
            .rst  (rst),
            .load (skid_load),
            .kill (lane_kill[i]),
            .d    (in_lane[i]),
            .q    (skid_q[i])
        );
    end

`else

    logic valid_q;
    logic out_xfer;

    // Accept when empty or when the held bundle leaves this same cycle.
    assign in_ready  = rst & (!valid_q | out_ready);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = valid_q & out_ready;
    assign out_valid = valid_q;
    assign main_load = in_xfer & !flush;
    assign main_d    = in_lane;
    assign main_kill = lane_kill;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_xfer) begin
            valid_q <= 1'b1;
        end else if (out_xfer) begin
            valid_q <= 1'b0;
        end
    end

`endif

    for (genvar i = 0; i < LANES; i++) begin : g_main
        vliw_lane_reg u_main (
            .clk  (clk),
            .rst  (rst),
            .load (main_load),
            .kill (main_kill[i]),
            .d    (main_d[i]),
            .q    (main_q[i])
        );
    end

    // Execute must never see a live slot while the stage is empty; the
    // other fields are left visible unchanged.
    always_comb begin
        out_lane = main_q;
        for (int i = 0; i < LANES; i++) begin
            if (!out_valid) begin
                out_lane[i] = force_nop(main_q[i]);
            end
        end
    end

endmodule

// File: tb/tb_vliw_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_vliw_id_ex_stage
// Self-checking bench for vliw_id_ex_stage. The reference model is a bundle
// queue of capacity 1 (or 2 when VLIW_ID_EX_SKID_EN is defined) plus the last
// bundle that reached the head, which is what the idle outputs show.
// ---------------------------------------------------------------------------
module tb_vliw_id_ex_stage;
    import vliw_pkg::*;

    localparam int LANES = 4;
`ifdef VLIW_ID_EX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef lane_t [LANES-1:0] bundle_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    bundle_t           in_lane;
    logic [LANES-1:0]  lane_kill;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    bundle_t           out_lane;

    int checks   = 0;
    int failures = 0;

    bundle_t    q[$];
    bundle_t    last_main;
    logic       exp_valid;
    logic       exp_ready;
    bundle_t    exp_lane;

    always #5 clk = ~clk;

    vliw_id_ex_stage #(.LANES(LANES), .OP_W(4), .REG_W(5), .IMM_W(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lane   (in_lane),
        .lane_kill (lane_kill),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lane  (out_lane)
    );

    function automatic bundle_t rand_bundle();
        bundle_t b;
        for (int i = 0; i < LANES; i++) begin
            b[i].op          = LANE_OP_W'($urandom);
            b[i].is_nop      = ($urandom_range(0, 3) == 0);
            b[i].is_imm_type = 1'($urandom);
            b[i].rs1         = LANE_REG_W'($urandom);
            b[i].rs2         = LANE_REG_W'($urandom);
            b[i].rd          = LANE_REG_W'($urandom);
            b[i].imm         = LANE_IMM_W'($urandom);
        end
        return b;
    endfunction

    function automatic logic model_ready();
        if (!rst) return 1'b0;
        if (CAP == 2) return (q.size() < 2);
        return (q.size() == 0) || out_ready;
    endfunction

    function automatic void predict();
        exp_valid = (q.size() > 0);
        exp_ready = model_ready();
        exp_lane  = exp_valid ? q[0] : last_main;
        if (!exp_valid) begin
            for (int i = 0; i < LANES; i++) exp_lane[i].is_nop = 1'b1;
        end
    endfunction

    task automatic drive(input logic v, input bundle_t b, input logic [LANES-1:0] k,
                         input logic f, input logic r);
        in_valid  = v;
        in_lane   = b;
        lane_kill = k;
        flush     = f;
        out_ready = r;
    endtask

    // Advance one clock and update the queue model from the inputs that
    // were presented during the cycle.
    task automatic advance();
        logic    inx;
        logic    outx;
        bundle_t cap;
        inx  = in_valid && model_ready();
        outx = (q.size() > 0) && out_ready;
        cap  = in_lane;
        for (int i = 0; i < LANES; i++) cap[i].is_nop = in_lane[i].is_nop | lane_kill[i];
        @(posedge clk);
        if (!rst) begin
            q.delete();
            last_main = {LANES{LANE_NOP}};
        end else if (flush) begin
            q.delete();
        end else begin
            if (outx) void'(q.pop_front());
            if (inx) q.push_back(cap);
        end
        if (q.size() > 0) last_main = q[0];
        #1;
    endtask

    task automatic test_reset();
        bundle_t b;
        rst = 1'b0;
        drive(1'b1, rand_bundle(), '0, 1'b0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            predict();
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset.in_ready got=%0b exp=0", in_ready);
            end
            if (c == 1) begin
                checks++;
                if (out_valid !== exp_valid || out_lane !== exp_lane) begin
                    failures++;
                    $display("[TB] FAIL reset.state valid=%0b/%0b lane=%h/%h", out_valid, exp_valid, out_lane, exp_lane);
                end
            end
            advance();
        end
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            b = rand_bundle();
            b[0].op = LANE_OP_W'(k);
            drive(k <= 4, b, '0, 1'b0, 1'b1);
            @(negedge clk);
            predict();
            checks++;
            if (in_ready !== exp_ready) begin
                failures++;
                $display("[TB] FAIL stream.in_ready got=%0b exp=%0b", in_ready, exp_ready);
            end
            checks++;
            if (out_valid !== exp_valid) begin
                failures++;
                $display("[TB] FAIL stream.out_valid got=%0b exp=%0b", out_valid, exp_valid);
            end
            checks++;
            if (out_lane !== exp_lane) begin
                failures++;
                $display("[TB] FAIL stream.out_lane got=%h exp=%h", out_lane, exp_lane);
            end
            if (k >= 2 && k <= 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_lane[0].op !== LANE_OP_W'(k - 1)) begin
                    failures++;
                    $display("[TB] FAIL stream.order valid=%0b op=%0d exp_op=%0d", out_valid, out_lane[0].op, k - 1);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        bundle_t    bun[3];
        int         idx;
        logic [3:0] seen[$];
        for (int j = 0; j < 3; j++) begin
            bun[j] = rand_bundle();
            bun[j][0].op = LANE_OP_W'(10 + j);
        end
        idx = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            drive(idx < 3, bun[idx < 3 ? idx : 0], '0, 1'b0, cyc >= 6);
            @(negedge clk);
            predict();
            checks++;
            if (in_ready !== exp_ready) begin
                failures++;
                $display("[TB] FAIL backpressure.in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_ready);
            end
            checks++;
            if (out_valid !== exp_valid || out_lane !== exp_lane) begin
                failures++;
                $display("[TB] FAIL backpressure.out cyc=%0d valid=%0b/%0b lane=%h/%h", cyc, out_valid, exp_valid, out_lane, exp_lane);
            end
            if (out_valid === 1'b1 && out_ready) seen.push_back(out_lane[0].op);
            if (in_valid && exp_ready) idx++;
            advance();
        end
        checks++;
        if (seen.size() != 3 || seen[0] != 4'hA || seen[1] != 4'hB || seen[2] != 4'hC) begin
            failures++;
            $display("[TB] FAIL backpressure.sequence got_count=%0d exp=A,B,C", seen.size());
        end
    endtask

    task automatic test_lane_kill();
        bundle_t b;
        logic [LANES-1:0] nops;
        b = rand_bundle();
        for (int i = 0; i < LANES; i++) b[i].is_nop = 1'b0;
        drive(1'b1, b, 4'b0101, 1'b0, 1'b1);
        @(negedge clk);
        advance();
        drive(1'b0, rand_bundle(), '0, 1'b0, 1'b1);
        @(negedge clk);
        predict();
        for (int i = 0; i < LANES; i++) nops[i] = out_lane[i].is_nop;
        checks++;
        if (out_valid !== 1'b1 || nops !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL kill.is_nop valid=%0b got=%b exp=0101", out_valid, nops);
        end
        checks++;
        if (out_lane[0].rd !== b[0].rd || out_lane[0].imm !== b[0].imm ||
            out_lane[2].rd !== b[2].rd || out_lane[2].imm !== b[2].imm) begin
            failures++;
            $display("[TB] FAIL kill.fields got=%h/%h exp=%h/%h", out_lane[0], out_lane[2], b[0], b[2]);
        end
        checks++;
        if (out_lane !== exp_lane) begin
            failures++;
            $display("[TB] FAIL kill.model got=%h exp=%h", out_lane, exp_lane);
        end
        advance();
    endtask

    task automatic test_flush_collision();
        bundle_t d;
        for (int c = 0; c < 3; c++) begin
            drive(c < 2, rand_bundle(), '0, 1'b0, 1'b0);
            @(negedge clk);
            advance();
        end
        d = rand_bundle();
        d[0].op = 4'hD;
        drive(1'b1, d, '0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush.pre_valid got=%0b exp=1", out_valid);
        end
        advance();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, rand_bundle(), '0, 1'b0, 1'b1);
            @(negedge clk);
            predict();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL flush.out_valid cyc=%0d got=%0b exp=0", c, out_valid);
            end
            checks++;
            if (out_lane !== exp_lane) begin
                failures++;
                $display("[TB] FAIL flush.out_lane cyc=%0d got=%h exp=%h", c, out_lane, exp_lane);
            end
            for (int i = 0; i < LANES; i++) begin
                checks++;
                if (out_lane[i].is_nop !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL flush.is_nop lane=%0d got=%0b exp=1", i, out_lane[i].is_nop);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_stall();
        bundle_t b;
        b = rand_bundle();
        b[0].imm = 20'hABCDE;
        drive(1'b1, b, '0, 1'b0, 1'b0);
        @(negedge clk);
        advance();
        drive(1'b0, rand_bundle(), '0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_lane[0].imm !== 20'hABCDE) begin
            failures++;
            $display("[TB] FAIL midreset.held valid=%0b imm=%h exp=abcde", out_valid, out_lane[0].imm);
        end
        advance();
        rst = 1'b0;
        drive(1'b1, rand_bundle(), '0, 1'b0, 1'b1);
        @(negedge clk);
        advance();
        rst = 1'b1;
        drive(1'b0, rand_bundle(), '0, 1'b0, 1'b0);
        @(negedge clk);
        predict();
        checks++;
        if (out_valid !== 1'b0 || out_lane[0].imm !== 20'h0) begin
            failures++;
            $display("[TB] FAIL midreset.after valid=%0b imm=%h exp=0/0", out_valid, out_lane[0].imm);
        end
        checks++;
        if (out_lane !== {LANES{LANE_NOP}}) begin
            failures++;
            $display("[TB] FAIL midreset.lanes got=%h exp=%h", out_lane, {LANES{LANE_NOP}});
        end
        advance();
    endtask

    task automatic test_idle_mask();
        bundle_t b;
        b = rand_bundle();
        for (int i = 0; i < LANES; i++) b[i].op = 4'd7;
        drive(1'b1, b, '0, 1'b0, 1'b1);
        @(negedge clk);
        advance();
        drive(1'b0, rand_bundle(), '0, 1'b0, 1'b1);
        @(negedge clk);
        advance();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle.out_valid got=%0b exp=0", out_valid);
        end
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (out_lane[i].op !== 4'd7 || out_lane[i].is_nop !== 1'b1) begin
                failures++;
                $display("[TB] FAIL idle.lane%0d op=%0d is_nop=%0b exp=7/1", i, out_lane[i].op, out_lane[i].is_nop);
            end
        end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) != 0);
            drive($urandom_range(0, 3) != 0, rand_bundle(),
                  ($urandom_range(0, 3) == 0) ? LANES'($urandom) : '0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
            @(negedge clk);
            predict();
            checks++;
            if (in_ready !== exp_ready) begin
                failures++;
                $display("[TB] FAIL random.in_ready cyc=%0d got=%0b exp=%0b", c, in_ready, exp_ready);
            end
            checks++;
            if (out_valid !== exp_valid) begin
                failures++;
                $display("[TB] FAIL random.out_valid cyc=%0d got=%0b exp=%0b", c, out_valid, exp_valid);
            end
            checks++;
            if (out_lane !== exp_lane) begin
                failures++;
                $display("[TB] FAIL random.out_lane cyc=%0d got=%h exp=%h", c, out_lane, exp_lane);
            end
            advance();
        end
        rst = 1'b1;
        drive(1'b0, rand_bundle(), '0, 1'b0, 1'b1);
    endtask

    initial begin
        last_main = {LANES{LANE_NOP}};
        test_reset();
        test_backpressure();
        test_lane_kill();
        test_flush_collision();
        test_reset_mid_stall();
        test_idle_mask();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vliw_id_ex_stage.md
# vliw_id_ex_stage

Parametrised, multi-lane decode-to-execute pipeline stage for the VLIW core. It carries one instruction bundle of `LANES` slots from decode to the execution units, using a valid/ready handshake instead of a bare stall input. It supports whole-stage flush and per-lane kill, and always presents killed or invalid slots to execute as NOPs. An optional skid entry registers the upstream ready path.

## Interface
Parameters:
- `LANES`, 4, issue slots per bundle (1..8)
- `OP_W`, 4, opcode width per lane
- `REG_W`, 5, register specifier width
- `IMM_W`, 20, immediate width

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; low = reset)
- `in_valid`  in  1  decode presents a bundle
- `in_ready`  out  1  stage accepts a bundle this cycle
- `in_lane`  in  LANES x lane_t  per-lane payload: op, is_nop, is_imm_type, rs1, rs2, rd, imm
- `lane_kill`  in  LANES  per-lane squash, applied when the bundle is captured
- `flush`  in  1  discard all held and incoming bundles
- `out_valid`  out  1  bundle available to execute
- `out_ready`  in  1  execute consumes the bundle this cycle
- `out_lane`  out  LANES x lane_t  registered per-lane payload

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Capture: for each lane, `is_nop = in_lane.is_nop | lane_kill[i]`. All other fields are captured unchanged, including for killed lanes.
- While `out_valid == 0`, `out_lane[i].is_nop` reads 1 on every lane (combinational mask). Other fields hold their last values.
- Hold: if `out_valid && !out_ready`, the main entry holds bit-exact.
- Flush: clears all valid bits on the next edge. A bundle offered in the same cycle is dropped, so flush wins over capture. Flush overrides a simultaneous out transfer only for the next cycle's state; the current cycle's output is already consumed.
- Reset (rst low at edge): `out_valid=0`, all stored `is_nop=1`, op/is_imm_type/rs1/rs2/rd/imm = 0, skid entry empty. Reset asserted mid-transfer discards everything.
- `in_ready` reads 0 on any cycle where `rst` is low.
- States (skid build): EMPTY, FULL (main only), SKID (main + skid).
  - EMPTY → FULL on in transfer.
  - FULL → EMPTY on out transfer without in transfer.
  - FULL → SKID on in transfer while `!out_ready`.
  - SKID → FULL on out transfer; the skid entry moves to main.
  - Any state → EMPTY on flush.
- Ordering: bundles leave in capture order. No duplication or loss except through flush or reset.

## Timing
- Latency: 1 cycle, from in transfer to `out_valid` with that bundle. Throughput is 1 bundle per cycle with `out_ready` held high.
- Without skid: `in_ready = rst & (!out_valid | out_ready)`. This is a combinational path from `out_ready`.
- With skid: `in_ready = rst & (state != SKID)`, a registered value independent of `out_ready`.
- `out_lane` and `out_valid` are register outputs, apart from the `is_nop` mask.

## Configuration
- `VLIW_ID_EX_SKID_EN` defined:
  - Adds the skid entry and the three-state FSM.
  - `in_ready` is registered.
  - Accepts one extra bundle after `out_ready` drops.
- Not defined:
  - Single entry; the state is just `out_valid`.
  - `in_ready` is combinational as above.
  - The SKID state does not exist.
  - Functional ordering and flush/kill behaviour are identical.

## Structure
- Package `vliw_pkg`:
  - `lane_t` packed struct, parameterised via package localparams matching the defaults above.
  - `LANE_NOP` constant (is_nop=1, all other fields 0), used for reset and mask.
  - FSM state enum `idex_state_e`.
- Sub-module `vliw_lane_reg`:
  - One lane's register with load enable, synchronous reset to `LANE_NOP`, and kill-to-NOP on capture.
  - Instantiated per lane for main and, under the macro, skid.

## Test plan
- Reset then stream: hold rst low for 2 cycles, then drive 4 bundles with op=1..4 on lane 0 and `out_ready=1`. Expect `out_valid` on cycles 1–4 with op=1,2,3,4. Expect `in_ready=0` during reset.
- Backpressure: deassert `out_ready` while driving bundles A, B, C.
  - Skid build: `in_ready` falls after B; C waits. Release gives A, B, C in order.
  - No skid: C is accepted only after A leaves. No bundle is lost or duplicated.
- Lane kill: in_lane is_nop=0 on all lanes, `lane_kill=4'b0101`. Expect out is_nop=`0101`, with rd/imm of lanes 0 and 2 preserved.
- Flush collision: while in SKID (or FULL), assert flush with `in_valid=1`. Next cycle `out_valid=0` and all out is_nop=1. The offered bundle never appears.
- Reset mid-stall: hold a bundle with imm=20'hABCDE, assert rst low for one edge. Expect `out_valid=0`, imm=0, and all is_nop=1 next cycle.
- Idle mask: with `out_valid=0` after a transfer of op=7, expect out op=7 still present and all is_nop=1.
